// File: rtl/sram_dp_tag_data_array_v2_pkg.sv
// Shared types and default geometry for the cache tag/data storage array.
package cache_array_pkg;

    localparam int SET_AW_DEF = 9;
    localparam int TAG_W_DEF  = 18;
    localparam int LINE_W_DEF = 512;

    // Metadata entry at the default tag width; the array builds its own row type from TAG_W.
    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_W_DEF-1:0] tag;
    } meta_t;

    typedef enum logic {S_INIT, S_READY} arr_state_t;

endpackage

// File: rtl/sram_dp_tag_data_array_v2_if.sv
// Request/response bundle between the cache controller (master) and the storage array (slave).
interface sram_dp_tag_data_array_v2_if #(
    parameter int SET_AW = cache_array_pkg::SET_AW_DEF,
    parameter int TAG_W  = cache_array_pkg::TAG_W_DEF,
    parameter int LINE_W = cache_array_pkg::LINE_W_DEF
);
    localparam int BE_W = LINE_W / 8;

    logic              init_done_o;
    logic              rden_i;
    logic [SET_AW-1:0] raddr_i;
    logic              rvalid_o;
    logic [TAG_W-1:0]  rdata_tag_o;
    logic              rdata_valid_o;
    logic              rdata_dirty_o;
    logic [LINE_W-1:0] rdata_data_o;
    logic              wren_i;
    logic [SET_AW-1:0] waddr_i;
    logic              wmeta_en_i;
    logic [TAG_W-1:0]  wdata_tag_i;
    logic              wvalid_i;
    logic              wdirty_i;
    logic [BE_W-1:0]   wbe_i;
    logic [LINE_W-1:0] wdata_data_i;

    modport master (
        input  init_done_o, rvalid_o, rdata_tag_o, rdata_valid_o, rdata_dirty_o, rdata_data_o,
        output rden_i, raddr_i, wren_i, waddr_i, wmeta_en_i, wdata_tag_i, wvalid_i, wdirty_i,
               wbe_i, wdata_data_i
    );

    modport slave (
        output init_done_o, rvalid_o, rdata_tag_o, rdata_valid_o, rdata_dirty_o, rdata_data_o,
        input  rden_i, raddr_i, wren_i, waddr_i, wmeta_en_i, wdata_tag_i, wvalid_i, wdirty_i,
               wbe_i, wdata_data_i
    );

endinterface

// File: rtl/sram_dp_tag_data_array_v2_bank.sv
// 1R1W data line storage with per-byte write enables and a registered read port.
module sram_bytewr_bank #(
    parameter int AW     = 9,
    parameter int LINE_W = 512,
    parameter int BE_W   = LINE_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [BE_W-1:0]   wbe_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [LINE_W-1:0] rdata_o
);
    localparam int DEPTH = 1 << AW;

    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wbe_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Read register captures the pre-write line on a same-address edge; the top merges the new bytes.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem[raddr_i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_dp_tag_data_array_v2.sv
// Dual-port cache set storage: metadata array with hardware clear, byte-enabled data bank,
// write-first collision bypass and held read outputs.
module sram_dp_tag_data_array_v2
    import cache_array_pkg::*;
#(
    parameter int SET_AW = SET_AW_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input logic                        clk,
    input logic                        rst_n,
    sram_dp_tag_data_array_v2_if.slave bus
);
    localparam int BE_W  = LINE_W / 8;
    localparam int DEPTH = 1 << SET_AW;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } meta_row_t;

    arr_state_t        state_q, state_d;
    logic [SET_AW-1:0] cnt_q, cnt_d;
    logic              rd_acc, wr_acc, coll;
    logic              meta_we;
    logic [SET_AW-1:0] meta_waddr;
    meta_row_t         meta_wdata, wmeta;
    meta_row_t         meta_mem [DEPTH];
    meta_row_t         rmeta_q, rmeta_d;
    logic              rvalid_q, rvalid_d;
    logic [BE_W-1:0]   mask_q, mask_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] bank_rdata;

    function automatic logic [LINE_W-1:0] byte_mask(input logic [BE_W-1:0] be);
        logic [LINE_W-1:0] m;
        for (int b = 0; b < BE_W; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    assign wmeta = {bus.wvalid_i, bus.wdirty_i, bus.wdata_tag_i};

    // INIT walks the clear counter over every set; request ports are dead until READY.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_acc     = 1'b0;
        wr_acc     = 1'b0;
        meta_we    = 1'b0;
        meta_waddr = bus.waddr_i;
        meta_wdata = wmeta;
        case (state_q)
            S_INIT: begin
                meta_we    = 1'b1;
                meta_waddr = cnt_q;
                meta_wdata = '0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = S_READY;
            end
            S_READY: begin
                rd_acc  = bus.rden_i;
                wr_acc  = bus.wren_i;
                meta_we = bus.wren_i & bus.wmeta_en_i;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign coll = rd_acc & wr_acc & (bus.raddr_i == bus.waddr_i);

    always_comb begin
        rvalid_d = rd_acc;
        rmeta_d  = rmeta_q;
        mask_d   = mask_q;
        wline_d  = wline_q;
        if (rd_acc) begin
            rmeta_d = (coll && bus.wmeta_en_i) ? wmeta : meta_mem[bus.raddr_i];
            mask_d  = coll ? bus.wbe_i : '0;
            if (coll) wline_d = bus.wdata_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rmeta_q  <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rmeta_q  <= rmeta_d;
            mask_q   <= mask_d;
        end
    end

    // Bypass line is only consulted through mask_q, which resets to zero.
    always_ff @(posedge clk) begin
        wline_q <= wline_d;
        if (meta_we) meta_mem[meta_waddr] <= meta_wdata;
    end

    sram_bytewr_bank #(
        .AW     (SET_AW),
        .LINE_W (LINE_W),
        .BE_W   (BE_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc),
        .waddr_i (bus.waddr_i),
        .wbe_i   (bus.wbe_i),
        .wdata_i (bus.wdata_data_i),
        .re_i    (rd_acc),
        .raddr_i (bus.raddr_i),
        .rdata_o (bank_rdata)
    );

    assign bus.init_done_o   = (state_q == S_READY);
    assign bus.rvalid_o      = rvalid_q;
    assign bus.rdata_tag_o   = rmeta_q.tag;
    assign bus.rdata_valid_o = rmeta_q.valid;
    assign bus.rdata_dirty_o = rmeta_q.dirty;
    assign bus.rdata_data_o  = (bank_rdata & ~byte_mask(mask_q)) | (wline_q & byte_mask(mask_q));

endmodule

// File: tb/tb_sram_dp_tag_data_array_v2.sv
// Randomised and directed checks of the cache storage array against an array-of-sets model.
module tb_sram_dp_tag_data_array_v2;
    import cache_array_pkg::*;

    localparam int SET_AW = SET_AW_DEF;
    localparam int TAG_W  = TAG_W_DEF;
    localparam int LINE_W = LINE_W_DEF;
    localparam int BE_W   = LINE_W / 8;
    localparam int DEPTH  = 1 << SET_AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_dp_tag_data_array_v2_if #(.SET_AW(SET_AW), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

    sram_dp_tag_data_array_v2 #(.SET_AW(SET_AW), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    meta_t             m_meta  [DEPTH];
    logic [LINE_W-1:0] m_data  [DEPTH];
    logic [BE_W-1:0]   m_known [DEPTH];

    logic              exp_rvalid;
    meta_t             exp_meta;
    logic [LINE_W-1:0] exp_data;
    logic [BE_W-1:0]   exp_known;
    logic [LINE_W-1:0] pat_a;

    function automatic logic [LINE_W-1:0] bytes_to_bits(input logic [BE_W-1:0] be);
        logic [LINE_W-1:0] m;
        for (int b = 0; b < BE_W; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic meta_t mk_meta(input logic v, input logic d, input logic [TAG_W-1:0] t);
        meta_t m;
        m.valid = v;
        m.dirty = d;
        m.tag   = t;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rden_i       = 1'b0;
        bus.raddr_i      = '0;
        bus.wren_i       = 1'b0;
        bus.waddr_i      = '0;
        bus.wmeta_en_i   = 1'b0;
        bus.wdata_tag_i  = '0;
        bus.wvalid_i     = 1'b0;
        bus.wdirty_i     = 1'b0;
        bus.wbe_i        = '0;
        bus.wdata_data_i = '0;
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            m_meta[a]  = '0;
            m_known[a] = '0;
        end
        exp_rvalid = 1'b0;
        exp_meta   = '0;
        exp_data   = '0;
        exp_known  = '1;
    endtask

    // One request cycle: the model commits the write before the read, which gives write-first.
    task automatic drive_cycle(input logic rd, input int ra, input logic wr, input int wa,
                               input logic men, input meta_t nm, input logic [BE_W-1:0] be,
                               input logic [LINE_W-1:0] d);
        bus.rden_i       = rd;
        bus.raddr_i      = SET_AW'(ra);
        bus.wren_i       = wr;
        bus.waddr_i      = SET_AW'(wa);
        bus.wmeta_en_i   = men;
        bus.wvalid_i     = nm.valid;
        bus.wdirty_i     = nm.dirty;
        bus.wdata_tag_i  = nm.tag;
        bus.wbe_i        = be;
        bus.wdata_data_i = d;
        if (wr) begin
            if (men) m_meta[wa] = nm;
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    m_data[wa][8*b +: 8] = d[8*b +: 8];
                    m_known[wa][b] = 1'b1;
                end
            end
        end
        exp_rvalid = rd;
        if (rd) begin
            exp_meta  = m_meta[ra];
            exp_data  = m_data[ra];
            exp_known = m_known[ra];
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        int cycles;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.init_done_o, bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got done/rvalid/valid/dirty=%b required 0000",
                     {bus.init_done_o, bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o});
        end
        n_checks++;
        if (bus.rdata_tag_o !== '0 || bus.rdata_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got tag=%h data=%h required 0", bus.rdata_tag_o, bus.rdata_data_o);
        end
        rst_n = 1'b1;
        cycles = 0;
        while (cycles < 1000) begin
            bus.rden_i  = 1'b1;
            bus.raddr_i = SET_AW'($urandom);
            tick();
            cycles++;
            n_checks++;
            if (bus.rvalid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL init_rvalid: got rvalid=%b at init cycle %0d required 0", bus.rvalid_o, cycles);
            end
            if (bus.init_done_o === 1'b1) break;
        end
        idle_inputs();
        n_checks++;
        if (cycles != DEPTH) begin
            n_fail++;
            $display("FAIL init_length: got %0d cycles required %0d", cycles, DEPTH);
        end
        model_clear();
    endtask

    task automatic test_init_clear();
        for (int a = 0; a < DEPTH; a++) begin
            drive_cycle(1'b1, a, 1'b0, 0, 1'b0, '0, '0, '0);
            n_checks++;
            if ({bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o} !== {3'b100, {TAG_W{1'b0}}}) begin
                n_fail++;
                $display("FAIL init_meta set %0d: got rvalid=%b valid=%b dirty=%b tag=%h required 1/0/0/0",
                         a, bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o);
            end
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < BE_W; i++) pat_a[8*i +: 8] = 8'(i * 3 + 8'h11);
        drive_cycle(1'b0, 0, 1'b1, 5, 1'b1, mk_meta(1'b1, 1'b0, 18'h2A5A5), '1, pat_a);
        n_checks++;
        if (bus.rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_no_rvalid: got rvalid=%b required 0", bus.rvalid_o);
        end
        drive_cycle(1'b1, 5, 1'b0, 0, 1'b0, '0, '0, '0);
        n_checks++;
        if ({bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o} !== {3'b110, 18'h2A5A5}) begin
            n_fail++;
            $display("FAIL wr_rd_meta: got rvalid=%b valid=%b dirty=%b tag=%h required 1/1/0/2a5a5",
                     bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o);
        end
        n_checks++;
        if (bus.rdata_data_o !== pat_a) begin
            n_fail++;
            $display("FAIL wr_rd_data: got %h required %h", bus.rdata_data_o, pat_a);
        end
    endtask

    task automatic test_byte_write();
        logic [LINE_W-1:0] d;
        d = rand_line();
        d[7:0] = 8'hFF;
        drive_cycle(1'b0, 0, 1'b1, 5, 1'b0, mk_meta(1'b0, 1'b1, 18'h3FFFF), BE_W'(1), d);
        drive_cycle(1'b1, 5, 1'b0, 0, 1'b0, '0, '0, '0);
        n_checks++;
        if (bus.rdata_data_o[7:0] !== 8'hFF || bus.rdata_data_o[LINE_W-1:8] !== pat_a[LINE_W-1:8]) begin
            n_fail++;
            $display("FAIL byte_write: got %h required byte0=ff rest=%h", bus.rdata_data_o, pat_a[LINE_W-1:8]);
        end
        n_checks++;
        if ({bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o} !== {2'b10, 18'h2A5A5}) begin
            n_fail++;
            $display("FAIL byte_write_meta: got valid=%b dirty=%b tag=%h required 1/0/2a5a5",
                     bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o);
        end
        drive_cycle(1'b0, 0, 1'b1, 5, 1'b0, mk_meta(1'b1, 1'b1, 18'h1), '0, rand_line());
        drive_cycle(1'b0, 0, 1'b0, 0, 1'b0, '0, '0, '0);
        n_checks++;
        if (bus.rvalid_o !== 1'b0 || bus.rdata_data_o[7:0] !== 8'hFF || bus.rdata_tag_o !== 18'h2A5A5) begin
            n_fail++;
            $display("FAIL hold: got rvalid=%b byte0=%h tag=%h required 0/ff/2a5a5",
                     bus.rvalid_o, bus.rdata_data_o[7:0], bus.rdata_tag_o);
        end
        drive_cycle(1'b1, 5, 1'b0, 0, 1'b0, '0, '0, '0);
        n_checks++;
        if (bus.rdata_tag_o !== 18'h2A5A5 || bus.rdata_data_o[LINE_W-1:8] !== pat_a[LINE_W-1:8]) begin
            n_fail++;
            $display("FAIL noop_write: got tag=%h data=%h required tag 2a5a5 unchanged line", bus.rdata_tag_o, bus.rdata_data_o);
        end
    endtask

    task automatic test_collision();
        logic [LINE_W-1:0] b_line, c_line, d_line, g_line;
        logic [BE_W-1:0]   upper;
        b_line = rand_line();
        c_line = rand_line();
        d_line = rand_line();
        g_line = rand_line();
        upper  = {{(BE_W/2){1'b1}}, {(BE_W/2){1'b0}}};
        drive_cycle(1'b0, 0, 1'b1, 7, 1'b1, mk_meta(1'b1, 1'b0, 18'h3C3C3), '1, b_line);
        drive_cycle(1'b1, 7, 1'b1, 7, 1'b1, mk_meta(1'b1, 1'b1, 18'h00123), upper, c_line);
        n_checks++;
        if ({bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o} !== {3'b111, 18'h00123}) begin
            n_fail++;
            $display("FAIL coll_meta: got rvalid=%b valid=%b dirty=%b tag=%h required 1/1/1/00123",
                     bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o);
        end
        n_checks++;
        if (bus.rdata_data_o !== {c_line[LINE_W-1:LINE_W/2], b_line[LINE_W/2-1:0]}) begin
            n_fail++;
            $display("FAIL coll_data: got %h required %h", bus.rdata_data_o,
                     {c_line[LINE_W-1:LINE_W/2], b_line[LINE_W/2-1:0]});
        end
        drive_cycle(1'b1, 7, 1'b1, 7, 1'b0, mk_meta(1'b0, 1'b0, 18'h3FFFF), '0, rand_line());
        n_checks++;
        if (bus.rdata_tag_o !== 18'h00123 || bus.rdata_data_o !== {c_line[LINE_W-1:LINE_W/2], b_line[LINE_W/2-1:0]}) begin
            n_fail++;
            $display("FAIL coll_nometa: got tag=%h required 00123 with stored line", bus.rdata_tag_o);
        end
        drive_cycle(1'b0, 0, 1'b1, 8, 1'b1, mk_meta(1'b1, 1'b0, 18'h00008), '1, d_line);
        drive_cycle(1'b1, 8, 1'b1, 9, 1'b1, mk_meta(1'b1, 1'b1, 18'h00009), '1, g_line);
        n_checks++;
        if (bus.rdata_tag_o !== 18'h00008 || bus.rdata_data_o !== d_line) begin
            n_fail++;
            $display("FAIL diff_addr: got tag=%h data=%h required tag 00008 data %h", bus.rdata_tag_o, bus.rdata_data_o, d_line);
        end
        drive_cycle(1'b1, 9, 1'b0, 0, 1'b0, '0, '0, '0);
        n_checks++;
        if (bus.rdata_tag_o !== 18'h00009 || bus.rdata_data_o !== g_line) begin
            n_fail++;
            $display("FAIL diff_addr_wr: got tag=%h data=%h required tag 00009 data %h", bus.rdata_tag_o, bus.rdata_data_o, g_line);
        end
    endtask

    task automatic test_random();
        logic [LINE_W-1:0] km;
        logic [BE_W-1:0]   be;
        for (int i = 0; i < 3000; i++) begin
            be = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) be = '0;
            if ($urandom_range(0, 7) == 0) be = '1;
            drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15),
                        $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                        $urandom_range(0, 1) == 1,
                        mk_meta(1'($urandom), 1'($urandom), 18'($urandom)), be, rand_line());
            km = bytes_to_bits(exp_known);
            n_checks++;
            if (bus.rvalid_o !== exp_rvalid ||
                {bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o} !== exp_meta ||
                (bus.rdata_data_o & km) !== (exp_data & km)) begin
                n_fail++;
                $display("FAIL random cycle %0d: got rvalid=%b meta=%h data=%h required rvalid=%b meta=%h data=%h",
                         i, bus.rvalid_o, {bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o},
                         bus.rdata_data_o & km, exp_rvalid, exp_meta, exp_data & km);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int cycles;
        drive_cycle(1'b0, 0, 1'b1, 3, 1'b1, mk_meta(1'b1, 1'b1, 18'h00333), '1, rand_line());
        drive_cycle(1'b1, 3, 1'b0, 0, 1'b0, '0, '0, '0);
        n_checks++;
        if ({bus.rdata_valid_o, bus.rdata_tag_o} !== {1'b1, 18'h00333}) begin
            n_fail++;
            $display("FAIL pre_reset: got valid=%b tag=%h required 1/00333", bus.rdata_valid_o, bus.rdata_tag_o);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({bus.init_done_o, bus.rvalid_o, bus.rdata_valid_o} !== 3'b0 || bus.rdata_tag_o !== '0 || bus.rdata_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset2: got done=%b rvalid=%b valid=%b tag=%h required all 0",
                     bus.init_done_o, bus.rvalid_o, bus.rdata_valid_o, bus.rdata_tag_o);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 200; c++) tick();
        n_checks++;
        if (bus.init_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clear_done: got %b required 0", bus.init_done_o);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bus.init_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_done: got %b required 0", bus.init_done_o);
        end
        rst_n = 1'b1;
        cycles = 0;
        while (cycles < 1000 && bus.init_done_o !== 1'b1) begin
            tick();
            cycles++;
        end
        n_checks++;
        if (cycles != DEPTH) begin
            n_fail++;
            $display("FAIL restart_length: got %0d cycles required %0d", cycles, DEPTH);
        end
        model_clear();
        drive_cycle(1'b1, 3, 1'b0, 0, 1'b0, '0, '0, '0);
        n_checks++;
        if ({bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o} !== {3'b100, {TAG_W{1'b0}}}) begin
            n_fail++;
            $display("FAIL post_reset_meta: got rvalid=%b valid=%b dirty=%b tag=%h required 1/0/0/0",
                     bus.rvalid_o, bus.rdata_valid_o, bus.rdata_dirty_o, bus.rdata_tag_o);
        end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_write_read();
        test_byte_write();
        test_collision();
        test_random();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
